// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: round-robin with bounded lock bursts.
// Define MEM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority, with requester 1 starved at most MAX_HOLD cycles.
module mem_port_arbiter #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [1:0]        owner
);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

    state_t          state, state_nxt;
    logic            rr, rr_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            cur, req_cur, lock_cur, req_oth, at_last, rotate, prefer1;

    always_comb begin
        cur      = (state == OWN1);
        req_cur  = cur ? req1 : req0;
        lock_cur = cur ? lock1 : lock0;
        req_oth  = cur ? req0 : req1;
        at_last  = (hold_cnt == HOLD_LAST);
`ifdef MEM_ARB_FIXED_PRIO_EN
        // requester 1 yields at once; requester 0 yields only at the hold limit or when it drops
        rotate   = cur ? req0 : (req1 && (at_last || !req0));
        prefer1  = 1'b0;
`else
        rotate   = req_oth && (!(lock_cur && req_cur) || at_last);
        prefer1  = rr;
`endif
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        hold_nxt  = '0;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = prefer1 ? OWN1 : OWN0;
                else if (req0)    state_nxt = OWN0;
                else if (req1)    state_nxt = OWN1;
            end
            default: begin
                if (rotate) begin
                    state_nxt = cur ? OWN0 : OWN1;
                    rr_nxt    = !cur;
                end else if (req_cur) begin
                    hold_nxt  = at_last ? hold_cnt : hold_cnt + 1'b1;
                end else begin
                    state_nxt = IDLE;
                    rr_nxt    = !cur;
                end
            end
        endcase
    end

    always_comb begin
        ack0      = (state == OWN0) && req0;
        ack1      = (state == OWN1) && req1;
        owner     = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ack0) begin
            mem_addr  = addr0;
            mem_wr    = we0;
            mem_rd    = !we0;
            mem_wdata = we0 ? wdata0 : '0;
        end else if (ack1) begin
            mem_addr  = addr1;
            mem_wr    = we1;
            mem_rd    = !we1;
            mem_wdata = we1 ? wdata1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            hold_cnt <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            rr       <= rr_nxt;
            hold_cnt <= hold_nxt;
            if (ack0 && !we0) rdata0 <= mem_rdata;
            if (ack1 && !we1) rdata1 <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MH = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam int CW_ACK1 = FIXED ? 3 : 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          ack0, ack1, mem_rd, mem_wr;
    logic [1:0]    owner;
    logic          preload;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
            mem[5] <= 8'hA5;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic a0, a1, e0;
        rst = 1'b0; preload = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_owner", owner, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        @(posedge clk); #1 rst = 1'b1;

        // single read of mem[5]
        @(posedge clk); #1 req0 = 1; we0 = 0; addr0 = 5; wdata0 = 8'hFF;
        @(negedge clk);
        chk("rd_c0_ack0", ack0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_c1_ack0", ack0, 1);
        chk("rd_c1_ack1", ack1, 0);
        chk("rd_c1_mem_rd", mem_rd, 1);
        chk("rd_c1_mem_wr", mem_wr, 0);
        chk("rd_c1_mem_addr", mem_addr, 5);
        chk("rd_c1_mem_wdata", mem_wdata, 0);
        chk("rd_c1_owner", owner, 1);
        @(posedge clk); #1 req0 = 0;
        @(negedge clk);
        chk("rd_c2_rdata0", rdata0, 8'hA5);
        chk("rd_c2_rdata1", rdata1, 0);
        chk("rd_c2_ack0", ack0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_c3_owner", owner, 0);

        // reset asserted mid-write
        @(posedge clk); #1 req0 = 1; we0 = 1; addr0 = 7; wdata0 = 8'h5A;
        @(posedge clk); #1;
        chk("mw_ack0", ack0, 1);
        chk("mw_mem_wr", mem_wr, 1);
        #2 rst = 1'b0;
        #1;
        chk("mw_rst_owner", owner, 0);
        chk("mw_rst_ack0", ack0, 0);
        chk("mw_rst_mem_wr", mem_wr, 0);
        chk("mw_rst_rdata0", rdata0, 0);
        @(posedge clk); #1 req0 = 0; we0 = 0;
        @(negedge clk);
        chk("mw_mem7_kept", mem[7], 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mw_idle_after", owner, 0);

        // both write addr 3 from idle
        @(posedge clk); #1
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 3; wdata1 = 8'h22;
        a0 = 0; a1 = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (a0) req0 = 0;
            if (a1) req1 = 0;
            @(negedge clk);
            chk($sformatf("cw_c%0d_ack0", c), ack0, (c == 1));
            chk($sformatf("cw_c%0d_ack1", c), ack1, (c == CW_ACK1));
            if (c == 1) chk("cw_c1_wdata", mem_wdata, 8'h11);
            a0 = ack0; a1 = ack1;
        end
        chk("cw_mem3", mem[3], 8'h22);
        we0 = 0; we1 = 0;
        repeat (2) @(posedge clk);

        // lock burst by requester 0 against requester 1
        #1 req0 = 1; lock0 = 1; addr0 = 5; req1 = 1; addr1 = 3;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("lb_c%0d_ack0", c), ack0, (c != 5));
            chk($sformatf("lb_c%0d_ack1", c), ack1, (c == 5));
        end
        chk("lb_rdata1", rdata1, 8'h22);
        chk("lb_rdata0", rdata0, 8'hA5);
        @(posedge clk); #1 req0 = 0; lock0 = 0; req1 = 0;

        // continuous unlocked contention from reset
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        req0 = 1; addr0 = 1; req1 = 1; addr1 = 2;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            e0 = FIXED ? (((c - 1) % 5) < 4) : ((c % 2) == 1);
            chk($sformatf("uc_c%0d_ack0", c), ack0, e0);
            chk($sformatf("uc_c%0d_ack1", c), ack1, !e0);
            chk($sformatf("uc_c%0d_owner", c), owner, e0 ? 2'b01 : 2'b10);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for the single-port data/program memory (AWIDTH address, DWIDTH data; synchronous write, combinational read).
- Requester 0 is the CPU instruction/data path. Requester 1 is the external loader/debug port.
- Grants one access per cycle, uses round-robin between requesters, supports bounded lock bursts, and returns registered read data per requester.
- Sits between the requesters and the memory enables/address mux. The top level handles bus tristating.

Parameters:
- AWIDTH, 5: memory address width.
- DWIDTH, 8: memory data width.
- MAX_HOLD, 4: maximum back-to-back accesses by a locked owner while the other requester waits. Legal range is 1 or more.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req0/req1  in  1  access request. Held with stable we/addr/wdata until ack.
- we0/we1  in  1  1=write, 0=read.
- lock0/lock1  in  1  request to keep ownership for further accesses.
- addr0/addr1  in  AWIDTH  access address.
- wdata0/wdata1  in  DWIDTH  write data.
- ack0/ack1  out  1  access performed this cycle. Combinational from owner state and req.
- rdata0/rdata1  out  DWIDTH  registered read data for that requester.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data (combinational).
- owner  out  2  00=idle, 01=req0, 10=req1.

Behaviour:
- State machine states: IDLE, OWN0, OWN1.
- Registers:
  - state.
  - rr pointer: 0 means requester 0 is preferred.
  - hold_cnt: width clog2(MAX_HOLD)+1, saturates at MAX_HOLD-1.
  - rdata0, rdata1.
- Reset (rst low, asynchronous): state=IDLE, rr=0, hold_cnt=0, rdata0=rdata1=0. Consequently owner=00, ack0=ack1=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-access aborts the access; no write occurs at that edge.
- IDLE:
  - No memory access; mem_* outputs are 0.
  - At the edge: if req0&req1, go to OWN[rr]. Else if one req is high, go to that OWN. Else stay.
  - hold_cnt=0.
- OWNx with req_x=1:
  - mem_addr=addr_x, mem_wr=we_x, mem_rd=!we_x, mem_wdata=wdata_x (0 on reads), ack_x=1.
  - The write commits at this edge.
  - On a read, rdata_x<=mem_rdata at this edge. rdata_x is otherwise held.
  - Latency: req raised in IDLE gives ack the next cycle and rdata valid the cycle after ack.
- Next state at each edge in OWNx (y = the other requester):
  - Rotate if req_y && (!(lock_x&&req_x) || hold_cnt==MAX_HOLD-1). Rotate means: go to OWNy, hold_cnt=0, rr=x+1 mod 2.
  - Else if req_x: stay in OWNx, hold_cnt increments (saturating).
  - Else: go to IDLE, hold_cnt=0, rr=y.
- OWNx with req_x=0 (requester withdrew; protocol violation): no access, no ack. Next state is decided by the same rule.
- lock with no competing request has no effect beyond normal continuation.
- Unlocked contention alternates 0,1,0,1 with no idle bubble.
- ack_y is never asserted while state=OWNx. At most one ack is high per cycle.
- MAX_HOLD=1: lock is effectively ignored under contention.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: rr is ignored and requester 0 wins every contention.
  - From IDLE with both requesting, go to OWN0.
  - From OWN1 with req0 pending, always go to OWN0 after the current access.
  - From OWN0 with req1 pending, rotate only when hold_cnt==MAX_HOLD-1, regardless of lock. This bounds starvation of requester 1 to MAX_HOLD cycles.
- Undefined: round-robin as above.

Test Plan:
- Reset: drive rst low mid-write in OWN0 → same cycle owner=00, ack0=0, mem_wr=0. The memory location is unchanged. After release with no requests, state stays IDLE.
- Single read: mem[5]=8'hA5, req0=1, we0=0, addr0=5 at cycle 0 → cycle 1: ack0=1, mem_rd=1, mem_addr=5. From cycle 2: rdata0=8'hA5. rdata1 stays 0.
- Contention from reset: req0 writes 8'h11 to addr 3 and req1 writes 8'h22 to addr 3 at cycle 0 → ack0 in cycle 1, ack1 in cycle 2, final mem[3]=8'h22.
- Lock burst: MAX_HOLD=4, req0=lock0=1 continuous, req1 raised at cycle 0 → ack0 in cycles 1-4, ack1 in cycle 5, ack0 in cycle 6.
- Unlocked continuous contention: req0=req1=1, no lock → acks alternate 0,1,0,1 from cycle 1. owner toggles 01/10 with no IDLE cycle.
- MEM_ARB_FIXED_PRIO_EN defined, MAX_HOLD=4, both requesting continuously → repeating pattern ack0 ×4, ack1 ×1.
